// File: rtl/data_sram_responder.sv
// data_sram_responder: target side of the single-cycle data SRAM port.
// Word-organised synchronous RAM with byte write enables and one-cycle read
// latency. Read data is held while idle. A write also returns the merged
// post-write word (write-first). Out-of-range accesses never touch the array,
// but they are still counted. The first one is captured in a sticky error register.
//
// Ports:
//   clk, resetn      clock, synchronous active-low reset
//   data_sram_en     access request this cycle
//   data_sram_we     byte write enables (nonzero = write, zero = read)
//   data_sram_addr   byte address, bits [1:0] ignored
//   data_sram_wdata  write data
//   data_sram_rdata  read data, valid the cycle after the request
//   rd_count         accepted reads, saturating
//   wr_count         accepted writes, saturating
//   err_oor          sticky out-of-range flag
//   err_addr         byte address of the first out-of-range access
module data_sram_responder #(
  parameter int unsigned DEPTH_LOG2 = 12,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
  parameter logic [31:0] OOR_DATA   = 32'hDEAD_BEEF
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        data_sram_en,
  input  logic [3:0]  data_sram_we,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic [31:0] data_sram_rdata,
  output logic [31:0] rd_count,
  output logic [31:0] wr_count,
  output logic        err_oor,
  output logic [31:0] err_addr
);

  localparam int unsigned Words = 1 << DEPTH_LOG2;
  // Byte span of the array. It is 33 bits wide so DEPTH_LOG2 = 30 does not overflow.
  localparam logic [32:0] Span  = 33'(4) << DEPTH_LOG2;

  logic [31:0] mem [Words];

  logic [31:0]           off;
  logic                  in_range;
  logic [DEPTH_LOG2-1:0] idx;
  logic                  is_rd, is_wr;
  logic [31:0]           cur_word, merged;

  logic [31:0] rdata_q, rdata_d;
  logic [31:0] rd_count_q, rd_count_d;
  logic [31:0] wr_count_q, wr_count_d;
  logic        err_q, err_d;
  logic [31:0] err_addr_q, err_addr_d;

  always_comb begin
    off      = data_sram_addr - BASE_ADDR;
    in_range = {1'b0, off} < Span;
    idx      = DEPTH_LOG2'(off >> 2);
    // Every decode result is qualified by en, so X on addr/we while idle is harmless.
    is_rd    = data_sram_en && (data_sram_we == 4'b0000);
    is_wr    = data_sram_en && (data_sram_we != 4'b0000);
    cur_word = mem[idx];
    merged   = cur_word;
    for (int i = 0; i < 4; i++) begin
      if (data_sram_we[i]) merged[8*i +: 8] = data_sram_wdata[8*i +: 8];
    end
  end

  always_comb begin
    rdata_d    = rdata_q;
    rd_count_d = rd_count_q;
    wr_count_d = wr_count_q;
    err_d      = err_q;
    err_addr_d = err_addr_q;
    if (is_rd) begin
      rdata_d = in_range ? cur_word : OOR_DATA;
      if (rd_count_q != 32'hFFFF_FFFF) rd_count_d = rd_count_q + 32'd1;
    end
    if (is_wr) begin
      if (in_range) rdata_d = merged;
      if (wr_count_q != 32'hFFFF_FFFF) wr_count_d = wr_count_q + 32'd1;
    end
    if (data_sram_en && !in_range && !err_q) begin
      err_d      = 1'b1;
      err_addr_d = data_sram_addr;
    end
  end

  // The array has no reset. Writes are still suppressed while resetn is low.
  always_ff @(posedge clk) begin
    if (resetn && is_wr && in_range) mem[idx] <= merged;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      rdata_q    <= 32'd0;
      rd_count_q <= 32'd0;
      wr_count_q <= 32'd0;
      err_q      <= 1'b0;
      err_addr_q <= 32'd0;
    end else begin
      rdata_q    <= rdata_d;
      rd_count_q <= rd_count_d;
      wr_count_q <= wr_count_d;
      err_q      <= err_d;
      err_addr_q <= err_addr_d;
    end
  end

  assign data_sram_rdata = rdata_q;
  assign rd_count        = rd_count_q;
  assign wr_count        = wr_count_q;
  assign err_oor         = err_q;
  assign err_addr        = err_addr_q;

endmodule

// File: tb/tb_data_sram_responder.sv
// Bench for data_sram_responder: directed table, hand-written multi-cycle
// sequences (mid-stream reset, counter saturation) and randomized traffic
// checked against a behavioural model.
module tb_data_sram_responder;

  logic        clk = 1'b0;
  logic        resetn;
  logic        en;
  logic [3:0]  we;
  logic [31:0] addr, wdata;
  logic [31:0] rdata, rc, wc, ea;
  logic        eo;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  data_sram_responder dut (
    .clk             (clk),
    .resetn          (resetn),
    .data_sram_en    (en),
    .data_sram_we    (we),
    .data_sram_addr  (addr),
    .data_sram_wdata (wdata),
    .data_sram_rdata (rdata),
    .rd_count        (rc),
    .wr_count        (wc),
    .err_oor         (eo),
    .err_addr        (ea)
  );

  typedef struct {
    logic        en;
    logic [3:0]  we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] x_rdata;
    logic [31:0] x_rc;
    logic [31:0] x_wc;
    logic        x_eo;
    logic [31:0] x_ea;
  } vec_t;

  vec_t vecs [17];

  // Behavioural model: word-addressed store plus the visible registers.
  logic [31:0] m_mem [int unsigned];
  logic [31:0] m_rdata, m_rc, m_wc, m_ea;
  logic        m_eo;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [31:0] x_rdata, input logic [31:0] x_rc,
                         input logic [31:0] x_wc, input logic x_eo, input logic [31:0] x_ea);
    chk({tag, " rdata"}, rdata, x_rdata);
    chk({tag, " rd_count"}, rc, x_rc);
    chk({tag, " wr_count"}, wc, x_wc);
    chk({tag, " err_oor"}, {31'd0, eo}, {31'd0, x_eo});
    chk({tag, " err_addr"}, ea, x_ea);
  endtask

  task automatic drive(input logic e, input logic [3:0] w, input logic [31:0] a,
                       input logic [31:0] d);
    en = e; we = w; addr = a; wdata = d;
  endtask

  // Inputs change 1 time unit after a rising edge; outputs are sampled at the same point.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_rdata = 0; m_rc = 0; m_wc = 0; m_eo = 0; m_ea = 0;
  endtask

  // Advance the model by one request and apply it to the DUT, then compare.
  task automatic model_cycle(input logic e, input logic [3:0] w, input logic [31:0] a,
                             input logic [31:0] d);
    logic [31:0]  word;
    int unsigned  wa;
    logic         inr;
    if (e) begin
      wa  = a >> 2;
      inr = a < 32'h4000;
      if (w == 4'b0000) begin
        if (m_rc != 32'hFFFF_FFFF) m_rc = m_rc + 1;
        m_rdata = inr ? m_mem[wa] : 32'hDEAD_BEEF;
      end else begin
        if (m_wc != 32'hFFFF_FFFF) m_wc = m_wc + 1;
        if (inr) begin
          word = m_mem.exists(wa) ? m_mem[wa] : 32'd0;
          for (int b = 0; b < 4; b++) if (w[b]) word[8*b +: 8] = d[8*b +: 8];
          m_mem[wa] = word;
          m_rdata   = word;
        end
      end
      if (!inr && !m_eo) begin
        m_eo = 1'b1;
        m_ea = a;
      end
    end
    drive(e, w, a, d);
    tick();
    chk_all("rand", m_rdata, m_rc, m_wc, m_eo, m_ea);
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    drive(1'b0, 4'h0, 32'h0, 32'h0);
    repeat (3) tick();
    resetn = 1'b1;
  endtask

  initial begin
    logic [31:0] pool [8];
    logic [31:0] a;
    logic [3:0]  w;
    logic        e;

    pool = '{32'h0000, 32'h0004, 32'h0100, 32'h3FFC, 32'h2000, 32'h1234, 32'h0800, 32'h0FF0};

    vecs[0]  = '{1'b1, 4'hF, 32'h0100, 32'h1234_5678, 32'h1234_5678, 0, 1, 1'b0, 32'h0};
    vecs[1]  = '{1'b1, 4'h0, 32'h0100, 32'h0,         32'h1234_5678, 1, 1, 1'b0, 32'h0};
    vecs[2]  = '{1'b1, 4'h5, 32'h0100, 32'hAABB_CCDD, 32'h12BB_56DD, 1, 2, 1'b0, 32'h0};
    vecs[3]  = '{1'b1, 4'h0, 32'h0103, 32'h0,         32'h12BB_56DD, 2, 2, 1'b0, 32'h0};
    vecs[4]  = '{1'b1, 4'h0, 32'h0100, 32'h0,         32'h12BB_56DD, 3, 2, 1'b0, 32'h0};
    for (int i = 5; i < 10; i++)
      vecs[i] = '{1'b0, 4'hF, 32'h4000, 32'hFFFF_FFFF, 32'h12BB_56DD, 3, 2, 1'b0, 32'h0};
    vecs[10] = '{1'b1, 4'hF, 32'h1000, 32'h55AA_55AA, 32'h55AA_55AA, 3, 3, 1'b0, 32'h0};
    vecs[11] = '{1'b1, 4'h0, 32'h4000, 32'h0,         32'hDEAD_BEEF, 4, 3, 1'b1, 32'h4000};
    vecs[12] = '{1'b1, 4'hF, 32'h5000, 32'h0102_0304, 32'hDEAD_BEEF, 4, 4, 1'b1, 32'h4000};
    vecs[13] = '{1'b1, 4'h0, 32'h1000, 32'h0,         32'h55AA_55AA, 5, 4, 1'b1, 32'h4000};
    vecs[14] = '{1'b1, 4'hF, 32'h3FFC, 32'h0BAD_F00D, 32'h0BAD_F00D, 5, 5, 1'b1, 32'h4000};
    vecs[15] = '{1'b1, 4'h0, 32'h3FFC, 32'h0,         32'h0BAD_F00D, 6, 5, 1'b1, 32'h4000};
    vecs[16] = '{1'b0, 4'h3, 32'h9000, 32'h0,         32'h0BAD_F00D, 6, 5, 1'b1, 32'h4000};

    resetn = 1'b0;
    drive(1'b0, 4'h0, 32'h0, 32'h0);
    #1;
    do_reset();
    chk_all("reset", 32'h0, 32'h0, 32'h0, 1'b0, 32'h0);

    for (int i = 0; i < 17; i++) begin
      drive(vecs[i].en, vecs[i].we, vecs[i].addr, vecs[i].wdata);
      tick();
      chk_all($sformatf("vec%0d", i), vecs[i].x_rdata, vecs[i].x_rc, vecs[i].x_wc,
              vecs[i].x_eo, vecs[i].x_ea);
    end

    // A write issued during reset is dropped and not counted.
    drive(1'b1, 4'hF, 32'h0200, 32'h2222_2222);
    tick();
    chk("pre-reset write rdata", rdata, 32'h2222_2222);
    resetn = 1'b0;
    drive(1'b1, 4'hF, 32'h0200, 32'h1111_1111);
    tick();
    chk_all("in reset", 32'h0, 32'h0, 32'h0, 1'b0, 32'h0);
    resetn = 1'b1;
    drive(1'b1, 4'h0, 32'h0200, 32'h0);
    tick();
    chk_all("post-reset read", 32'h2222_2222, 32'h1, 32'h0, 1'b0, 32'h0);
    drive(1'b1, 4'hF, 32'h0200, 32'h3333_3333);
    tick();
    chk_all("post-reset write", 32'h3333_3333, 32'h1, 32'h1, 1'b0, 32'h0);

    // Randomized traffic against the model. The pool words are preloaded so every read has a defined value.
    do_reset();
    model_reset();
    for (int i = 0; i < 8; i++) model_cycle(1'b1, 4'hF, pool[i], $urandom);
    for (int n = 0; n < 400; n++) begin
      e = $urandom_range(0, 3) != 0;
      w = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 15)) : 4'h0;
      if ($urandom_range(0, 15) == 0) a = 32'h4000 + $urandom_range(0, 32'hFFFF);
      else a = pool[$urandom_range(0, 7)] | 32'($urandom_range(0, 3));
      if (!e) begin
        w = 4'($urandom);
        a = $urandom;
      end
      model_cycle(e, w, a, $urandom);
    end

    // Write counter saturation.
    do_reset();
    @(negedge clk);
    force dut.wr_count_q = 32'hFFFF_FFFE;
    @(posedge clk);
    @(negedge clk);
    release dut.wr_count_q;
    #1;
    chk("sat preload", wc, 32'hFFFF_FFFE);
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 4'hF, 32'h0040, 32'(i));
      tick();
      chk($sformatf("sat write%0d", i), wc, 32'hFFFF_FFFF);
    end
    drive(1'b0, 4'h0, 32'h0, 32'h0);
    tick();
    chk("sat hold", wc, 32'hFFFF_FFFF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
